dsdmnist_acc_requant: RTL and testbench

Consumer end of the MAC datapath. Accepts finished 32-bit signed accumulator values through a valid/ready handshake. Per item it applies bias add, rounding arithmetic right shift, optional ReLU and int8 saturation. Emits int8 activations to the next layer's operand buffer through a valid/ready handshake, with a 3-stage pipeline and full backpressure.

---
 rtl/dsdmnist_acc_requant_pkg.sv | 21 ++
 rtl/dsdmnist_acc_requant_round_sat.sv | 41 ++++
 rtl/dsdmnist_acc_requant.sv | 89 ++++++++
 tb/tb_dsdmnist_acc_requant.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dsdmnist_acc_requant_pkg.sv
// Shared widths, types and the stage-1 pipeline record for the requantizer.
package dsdmnist_pkg;
   localparam int ACCW  = 32;
   localparam int BIASW = 16;
   localparam int SHW   = 5;
   localparam int OUTW  = 8;
   // Two guard bits: room for the bias add and the rounding increment
   localparam int SUMW  = ACCW + 2;

   typedef logic signed [ACCW-1:0] acc_t;
   typedef logic signed [OUTW-1:0] q8_t;
   typedef logic        [SHW-1:0]  shamt_t;
   typedef logic signed [SUMW-1:0] sum_t;

   typedef struct packed {
      logic   valid;
      sum_t   data;
      shamt_t shift;
      logic   relu;
   } rq_stage_t;
endpackage

// File: rtl/dsdmnist_acc_requant_round_sat.sv
// Combinational helpers: rounding arithmetic right shift, and ReLU + int8 saturation.
module dsdmnist_round_sat
   import dsdmnist_pkg::*;
(
   input  sum_t   sum_i,
   input  shamt_t shift_i,
   output sum_t   rnd_o,
   input  sum_t   r_i,
   input  logic   relu_i,
   output q8_t    q_o,
   output logic   sat_o
);
   localparam sum_t QMAX   = sum_t'((2 ** (OUTW - 1)) - 1);
   localparam sum_t QMIN   = -QMAX - sum_t'(1);
   localparam q8_t  Q8_MAX = q8_t'((2 ** (OUTW - 1)) - 1);
   localparam q8_t  Q8_MIN = ~Q8_MAX;

   sum_t half;

   // Round half up: add 2^(shift-1) before the arithmetic shift; shift 0 adds nothing
   always_comb begin
      half = '0;
      if (shift_i != '0) half = sum_t'(1) << (shift_i - shamt_t'(1));
      rnd_o = (sum_i + half) >>> shift_i;
   end

   // ReLU takes priority and never counts as a saturation event
   always_comb begin
      q_o   = r_i[OUTW-1:0];
      sat_o = 1'b0;
      if (relu_i && r_i[SUMW-1]) begin
         q_o = '0;
      end else if (r_i > QMAX) begin
         q_o   = Q8_MAX;
         sat_o = 1'b1;
      end else if (r_i < QMIN) begin
         q_o   = Q8_MIN;
         sat_o = 1'b1;
      end
   end
endmodule

// File: rtl/dsdmnist_acc_requant.sv
// Accumulator requantizer: bias add -> rounding shift -> ReLU/saturate, 3 stages,
// one global enable so a stalled output freezes the whole pipe (bubbles kept).
module dsdmnist_acc_requant
   import dsdmnist_pkg::*;
(
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic signed [ACCW-1:0] i_ACC,
   input  logic signed [BIASW-1:0] i_BIAS,
   input  logic [SHW-1:0]         i_SHIFT,
   input  logic                   i_RELU,
   input  logic                   i_ACC_VALID,
   output logic                   o_ACC_READY,
   output logic signed [OUTW-1:0] o_DATA,
   output logic                   o_VALID,
   input  logic                   i_READY,
   output logic                   o_SAT,
   input  logic                   i_SAT_CLR
);
   rq_stage_t s1_q, s1_d;
   logic      s2_vld_q;
   sum_t      s2_r_q;
   logic      s2_relu_q;
   logic      out_vld_q;
   q8_t       out_q;
   logic      sat_q, sat_d;
   sum_t      rnd;
   q8_t       q;
   logic      sat;
   logic      en;

   // Only a held, unaccepted output blocks progress
   assign en          = !(out_vld_q && !i_READY);
   assign o_ACC_READY = en;
   assign o_VALID     = out_vld_q;
   assign o_DATA      = out_q;
   assign o_SAT       = sat_q;

   dsdmnist_round_sat u_rs (
      .sum_i   (s1_q.data),
      .shift_i (s1_q.shift),
      .rnd_o   (rnd),
      .r_i     (s2_r_q),
      .relu_i  (s2_relu_q),
      .q_o     (q),
      .sat_o   (sat)
   );

   // Stage-1 capture: sign-extended bias add plus per-item controls
   always_comb begin
      s1_d       = '0;
      s1_d.valid = i_ACC_VALID;
      s1_d.data  = sum_t'(i_ACC) + sum_t'(i_BIAS);
      s1_d.shift = i_SHIFT;
      s1_d.relu  = i_RELU;
   end

   // Sticky saturation: a saturating load into the output stage beats a clear
   always_comb begin
      sat_d = sat_q;
      if (i_SAT_CLR) sat_d = 1'b0;
      if (en && s2_vld_q && sat) sat_d = 1'b1;
   end

   // Pipeline registers, all advancing together on en
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         s1_q      <= '0;
         s2_vld_q  <= 1'b0;
         s2_r_q    <= '0;
         s2_relu_q <= 1'b0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else if (en) begin
         s1_q      <= s1_d;
         s2_vld_q  <= s1_q.valid;
         s2_r_q    <= rnd;
         s2_relu_q <= s1_q.relu;
         out_vld_q <= s2_vld_q;
         if (s2_vld_q) out_q <= q;
      end
   end

   // Saturation flag register
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end
endmodule

// File: tb/tb_dsdmnist_acc_requant.sv
// Directed + random bench for the requantizer with an arithmetic reference model.
module tb_dsdmnist_acc_requant;
   logic               i_CLK = 1'b0;
   logic               i_RST;
   logic signed [31:0] i_ACC;
   logic signed [15:0] i_BIAS;
   logic [4:0]         i_SHIFT;
   logic               i_RELU, i_ACC_VALID, o_ACC_READY;
   logic signed [7:0]  o_DATA;
   logic               o_VALID, i_READY, o_SAT, i_SAT_CLR;

   int     errs = 0, checks = 0;
   longint exp_q[$];
   bit     exp_sat_q[$];

   dsdmnist_acc_requant dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_ACC(i_ACC), .i_BIAS(i_BIAS), .i_SHIFT(i_SHIFT),
      .i_RELU(i_RELU), .i_ACC_VALID(i_ACC_VALID), .o_ACC_READY(o_ACC_READY),
      .o_DATA(o_DATA), .o_VALID(o_VALID), .i_READY(i_READY), .o_SAT(o_SAT),
      .i_SAT_CLR(i_SAT_CLR)
   );

   always #5 i_CLK = ~i_CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Exact arithmetic: floor((acc+bias)/2^sh + 1/2), then ReLU and clip
   function automatic longint ref_q(input longint acc, input longint bias, input int sh,
                                    input bit relu, output bit sat);
      longint s, r, d, n;
      s = acc + bias;
      if (sh == 0) r = s;
      else begin
         d = longint'(1) << sh;
         n = s + d / 2;
         r = n / d;
         if ((n % d != 0) && (n < 0)) r = r - 1;
      end
      sat = 1'b0;
      if (relu && r < 0) return 0;
      if (r > 127)  begin sat = 1'b1; return 127;  end
      if (r < -128) begin sat = 1'b1; return -128; end
      return r;
   endfunction

   // One cycle: drive after negedge, sample before the next posedge
   task automatic step(input bit v, input longint acc, input longint bias, input int sh,
                       input bit relu, input bit rdy, input bit clr, output bit fired);
      longint e;
      bit     es;
      @(negedge i_CLK);
      i_ACC_VALID = v; i_ACC = acc[31:0]; i_BIAS = bias[15:0]; i_SHIFT = sh[4:0];
      i_RELU = relu; i_READY = rdy; i_SAT_CLR = clr;
      #1;
      chk("acc_ready", o_ACC_READY, !(o_VALID && !i_READY));
      if (o_VALID && i_READY) begin
         if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            e  = exp_q.pop_front();
            es = exp_sat_q.pop_front();
            chk("data", $signed(o_DATA), e);
            if (es) chk("sat_sticky", o_SAT, 1);
         end
      end
      fired = v && o_ACC_READY;
      if (fired) begin
         exp_q.push_back(ref_q(acc, bias, sh, relu, es));
         exp_sat_q.push_back(es);
      end
   endtask

   task automatic bubble(input bit rdy, input bit clr);
      bit f;
      step(0, 0, 0, 0, 0, rdy, clr, f);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || o_VALID) && n < maxc) begin
         bubble(1, 0);
         n++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      bit     f;
      int     idx;
      longint a;
      i_RST = 1'b1; i_ACC = '0; i_BIAS = '0; i_SHIFT = '0; i_RELU = 0;
      i_ACC_VALID = 0; i_READY = 1; i_SAT_CLR = 0;
      #1;
      chk("rst_valid", o_VALID, 0);
      chk("rst_data", $signed(o_DATA), 0);
      chk("rst_sat", o_SAT, 0);
      @(negedge i_CLK); @(negedge i_CLK);
      i_RST = 1'b0;

      // Overflowing round: (1024+4)>>3 = 128 clips to 127, three-cycle latency
      step(1, 1000, 24, 3, 0, 1, 0, f);
      bubble(1, 0); chk("lat_c1", o_VALID, 0);
      bubble(1, 0); chk("lat_c2", o_VALID, 0);
      bubble(1, 0); chk("lat_c3", o_VALID, 1);
      chk("sat_set", o_SAT, 1);
      bubble(1, 1);
      bubble(1, 0); chk("sat_cleared", o_SAT, 0);

      // Negative rounding, ReLU, half-up rounding
      step(1, -300, 0, 2, 0, 1, 0, f);
      step(1, -300, 0, 2, 1, 1, 0, f);
      step(1, 5, 0, 1, 0, 1, 0, f);
      step(1, -5, 0, 1, 0, 1, 0, f);
      drain(10);
      chk("no_sat_burst", o_SAT, 0);

      // Most negative input with most negative bias: clip, no wrap
      a = -64'sd2147483648;
      step(1, a, -32768, 0, 0, 1, 0, f);
      drain(10);
      chk("sat_min", o_SAT, 1);
      bubble(1, 1);
      bubble(1, 0); chk("sat_cleared2", o_SAT, 0);

      // Clear coinciding with a saturating load: set wins
      step(1, 1000000, 0, 0, 0, 1, 0, f);
      bubble(1, 0);
      bubble(1, 1);
      bubble(1, 0); chk("sat_set_wins", o_SAT, 1);
      drain(10);

      // Stream of 10 with toggling downstream ready
      idx = 0;
      for (int t = 0; t < 80 && idx < 10; t++) begin
         step(1, 8 * idx, 0, 3, 0, t[0], 0, f);
         if (f) idx++;
      end
      chk("stream_sent", idx, 10);
      drain(40);

      // Sustained stall: only three items fit
      idx = 0;
      for (int t = 0; t < 10; t++) begin
         step(idx < 5, 8 * (20 + idx), 0, 3, 0, 0, 0, f);
         if (f) idx++;
      end
      chk("stall_accepted", idx, 3);
      chk("stall_ready_low", o_ACC_READY, 0);
      for (int t = 0; t < 30 && idx < 5; t++) begin
         step(1, 8 * (20 + idx), 0, 3, 0, 1, 0, f);
         if (f) idx++;
      end
      chk("stall_all_sent", idx, 5);
      drain(20);

      // Random traffic against the model
      for (int t = 0; t < 120; t++) begin
         a = $signed($urandom);
         a = a >>> $urandom_range(0, 31);
         step($urandom_range(0, 3) != 0, a, int'($urandom_range(0, 65535)) - 32768,
              $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 2) != 0, 0, f);
      end
      drain(40);

      // Reset with two items in flight, output held
      bubble(1, 1);
      bubble(0, 0); chk("pre_rst_sat_clr", o_SAT, 0);
      step(1, 1000000, 0, 0, 0, 0, 0, f);
      step(1, 1000000, 0, 0, 0, 0, 0, f);
      bubble(0, 0);
      bubble(0, 0);
      chk("pre_rst_valid", o_VALID, 1);
      chk("pre_rst_sat", o_SAT, 1);
      @(negedge i_CLK);
      i_RST = 1'b1;
      #1;
      chk("rst2_valid", o_VALID, 0);
      chk("rst2_data", $signed(o_DATA), 0);
      chk("rst2_sat", o_SAT, 0);
      exp_q.delete();
      exp_sat_q.delete();
      @(negedge i_CLK);
      i_RST = 1'b0;
      for (int t = 0; t < 6; t++) bubble(1, 0);
      chk("post_rst_quiet", o_VALID, 0);
      chk("post_rst_sat", o_SAT, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
